// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver: serialises a parallel word into a daisy chain of 74HC595s.
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   data     in   word to shift out, captured at frame start
//   start    in   frame request, honoured only while idle
//   busy     out  high while a frame is shifting or latching
//   done     out  one-clk pulse as RCLK falls at frame end
//   srclk    out  595 shift clock
//   rclk     out  595 storage (latch) clock
//   dio      out  595 serial data
//   oe_n     out  595 output enable, held high until the first frame is latched
module hc595_chain_driver #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int SRCLK_FREQ   = 12_500_000,
    parameter int NUM_BYTES    = 2,
    parameter bit MSB_FIRST    = 1'b1,
    parameter bit AUTO_REFRESH = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [8*NUM_BYTES-1:0] data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   srclk,
    output logic                   rclk,
    output logic                   dio,
    output logic                   oe_n
);
    localparam int HALF_DIV = CLK_FREQ / (2 * SRCLK_FREQ);
    localparam int BITS     = 8 * NUM_BYTES;
    localparam int DW       = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;
    localparam int CW       = $clog2(BITS);

    if (HALF_DIV < 1) begin : g_bad_half_div
        $error("hc595_chain_driver: CLK_FREQ/(2*SRCLK_FREQ) must be >= 1");
    end
    if (NUM_BYTES < 1 || NUM_BYTES > 16) begin : g_bad_num_bytes
        $error("hc595_chain_driver: NUM_BYTES must be 1..16");
    end

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] shadow_q, shadow_d;
    logic            busy_q, busy_d, done_q, done_d, srclk_q, srclk_d;
    logic            rclk_q, rclk_d, oe_n_q, oe_n_d;
    logic            tick, go, last, adv;

    assign tick = state_q != IDLE && div_q == DW'(HALF_DIV - 1);
    assign go   = state_q == IDLE && (start || AUTO_REFRESH);
    assign last = cnt_q == CW'(BITS - 1);
    assign adv  = tick && state_q == SHIFT_HI && !last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            srclk_q  <= 1'b0;
            rclk_q   <= 1'b0;
            oe_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            srclk_q  <= srclk_d;
            rclk_q   <= rclk_d;
            oe_n_q   <= oe_n_d;
        end
    end

    always_comb begin
        state_d = go ? SHIFT_LO
                : !tick ? state_q
                : state_q == SHIFT_LO ? SHIFT_HI
                : state_q == SHIFT_HI ? (last ? LATCH : SHIFT_LO)
                : IDLE;
    end

    // Pin outputs are registered from the next state so they change cleanly on clk.
    // The serial bit is always the head of the shadow register, which only moves
    // as SRCLK falls, so dio is stable across every SRCLK rise.
    always_comb begin
        div_d    = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
        cnt_d    = go ? '0 : adv ? cnt_q + 1'b1 : cnt_q;
        shadow_d = go ? data : adv ? (MSB_FIRST ? shadow_q << 1 : shadow_q >> 1) : shadow_q;
        busy_d   = state_d != IDLE;
        srclk_d  = state_d == SHIFT_HI;
        rclk_d   = state_d == LATCH;
        done_d   = state_q == LATCH && tick;
        oe_n_d   = done_d ? 1'b0 : oe_n_q;
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign srclk = srclk_q;
    assign rclk  = rclk_q;
    assign dio   = MSB_FIRST ? shadow_q[BITS-1] : shadow_q[0];
    assign oe_n  = oe_n_q;
endmodule

// File: tb/tb_hc595_chain_driver.sv
// tb_hc595_chain_driver: self-checking bench for hc595_chain_driver.
module tb_hc595_chain_driver;
    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [15:0] data = '0;
    logic        busy, done, srclk, rclk, dio, oe_n;
    logic        b_busy, b_done, b_srclk, b_rclk, b_dio, b_oe_n;

    hc595_chain_driver dut (
        .clk(clk), .reset_n(reset_n), .data(data), .start(start),
        .busy(busy), .done(done), .srclk(srclk), .rclk(rclk), .dio(dio), .oe_n(oe_n)
    );

    hc595_chain_driver #(.MSB_FIRST(1'b0), .AUTO_REFRESH(1'b1)) dut_auto (
        .clk(clk), .reset_n(reset_n), .data(16'h0001), .start(1'b0),
        .busy(b_busy), .done(b_done), .srclk(b_srclk), .rclk(b_rclk), .dio(b_dio), .oe_n(b_oe_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [15:0] exp_word;
        int          exp_busy;
    } vec_t;

    int          n_cmp = 0, n_err = 0;
    logic [15:0] expq[$];
    logic        pa_srclk = 0, pa_rclk = 0, pa_busy = 0, pa_done = 0;
    logic        pb_srclk = 0, pb_rclk = 0, pb_busy = 0, b_seen = 0;
    int          a_bits = 0, a_busy = 0, a_rw = 0, a_frames = 0, a_dones = 0;
    int          b_bits = 0, b_low = 0, b_frames = 0;
    logic [15:0] a_sh = '0, b_sh = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Observes both DUTs once per falling edge; expected frames come from expq.
    task automatic mon();
        if (!reset_n) begin
            a_bits = 0; a_busy = 0; a_rw = 0; a_sh = '0;
            b_bits = 0; b_low = 0; b_sh = '0; b_seen = 0;
            pa_srclk = 0; pa_rclk = 0; pa_busy = 0; pa_done = 0;
            pb_srclk = 0; pb_rclk = 0; pb_busy = 0;
        end else begin
            if (srclk && !pa_srclk) begin a_sh = {a_sh[14:0], dio}; a_bits++; end
            if (busy) a_busy++;
            if (!busy && pa_busy) begin
                chk("busy_len", a_busy, 66);
                chk("done_after_busy", done, 1);
                a_busy = 0;
            end
            if (done) begin chk("done_width", pa_done, 0); a_dones++; end
            if (rclk) a_rw++;
            if (rclk && !pa_rclk) begin
                chk("bits_per_frame", a_bits, 16);
                if (expq.size() == 0) chk("unexpected_frame", 1, 0);
                else chk("frame_word", a_sh, expq.pop_front());
                a_frames++;
                a_bits = 0;
            end
            if (!rclk && pa_rclk) begin chk("rclk_width", a_rw, 2); a_rw = 0; end
            if (b_srclk && !pb_srclk) begin b_sh = {b_sh[14:0], b_dio}; b_bits++; end
            if (!b_busy) b_low++;
            if (b_busy && !pb_busy) begin
                if (b_seen) chk("auto_gap", b_low, 1);
                b_low = 0;
            end
            if (b_rclk && !pb_rclk) begin
                chk("auto_bits", b_bits, 16);
                chk("auto_word", b_sh, 16'h8000);
                b_frames++;
                b_bits = 0;
                b_seen = 1;
            end
            pa_srclk = srclk; pa_rclk = rclk; pa_busy = busy; pa_done = done;
            pb_srclk = b_srclk; pb_rclk = b_rclk; pb_busy = b_busy;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
    endtask

    task automatic wait_dones(input int target, input string name);
        int k = 0;
        while (a_dones < target && k < 500) begin cyc(); k++; end
        chk(name, a_dones, target);
    endtask

    initial begin
        vec_t vt[5];
        int   base;
        vt[0] = '{16'hA5C3, 16'hA5C3, 66};
        vt[1] = '{16'h0000, 16'h0000, 66};
        vt[2] = '{16'hFFFF, 16'hFFFF, 66};
        vt[3] = '{16'h8001, 16'h8001, 66};
        vt[4] = '{16'h7E5A, 16'h7E5A, 66};

        repeat (3) cyc();
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
        chk("rst_srclk", srclk, 0); chk("rst_rclk", rclk, 0);
        chk("rst_dio", dio, 0);     chk("rst_oe_n", oe_n, 1);
        chk("rst_b_busy", b_busy, 0);   chk("rst_b_done", b_done, 0);
        chk("rst_b_srclk", b_srclk, 0); chk("rst_b_rclk", b_rclk, 0);
        chk("rst_b_dio", b_dio, 0);     chk("rst_b_oe_n", b_oe_n, 1);
        reset_n = 1'b1;
        cyc();
        chk("oe_n_before_frame", oe_n, 1);

        for (int i = 0; i < 5; i++) begin
            data = vt[i].d;
            expq.push_back(vt[i].exp_word);
            start = 1'b1;
            cyc();
            start = 1'b0;
            chk("busy_after_start", busy, 1);
            base = a_busy;
            wait_dones(a_dones + 1, "frame_done");
            chk("busy_total", base + 1 <= vt[i].exp_busy, 1);
            chk("oe_n_after_frame", oe_n, 0);
            repeat (3) cyc();
        end

        base = a_frames;
        data = 16'h1234;
        expq.push_back(16'h1234);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (10) cyc();
        data = 16'hFFFF;
        start = 1'b1;
        cyc();
        start = 1'b0;
        data = 16'h0F0F;
        wait_dones(a_dones + 1, "snapshot_done");
        repeat (20) cyc();
        chk("no_queued_start", busy, 0);
        chk("single_frame", a_frames - base, 1);

        base = a_dones;
        data = 16'h3C96;
        repeat (3) expq.push_back(16'h3C96);
        start = 1'b1;
        for (int k = 0; k < 400; k++) begin
            cyc();
            if (done) begin
                chk("b2b_gap_idle", busy, 0);
                if (a_dones == base + 3) begin start = 1'b0; break; end
                cyc();
                chk("b2b_restart", busy, 1);
            end
        end
        start = 1'b0;
        chk("b2b_frames", a_dones, base + 3);
        repeat (10) cyc();
        chk("b2b_stopped", busy, 0);

        base = a_frames;
        data = 16'hFFFF;
        expq.push_back(16'hFFFF);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 200 && a_bits < 7; k++) cyc();
        chk("abort_at_bit7", a_bits, 7);
        reset_n = 1'b0;
        expq.delete();
        cyc();
        cyc();
        chk("abort_busy", busy, 0);
        chk("abort_rclk", rclk, 0);
        chk("abort_oe_n", oe_n, 1);
        reset_n = 1'b1;
        repeat (40) cyc();
        chk("abort_no_latch", a_frames, base);
        chk("abort_oe_n_held", oe_n, 1);

        repeat (150) cyc();
        chk("auto_refresh_frames", b_frames >= 5, 1);
        chk("auto_oe_n", b_oe_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
